// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared FSM encoding, control-unit ALUop constants and default bus timeout.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] ALUOP_LW = 5'b10100;
  localparam logic [4:0] ALUOP_SW = 5'b10101;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts bus wait cycles and flags the last permitted cycle.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired_o = count_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign count_o   = count_q;

  // Saturates at the limit so a held enable can never wrap back to zero.
  always_comb count_d = clear_i ? '0 : (enable_i && !expired_o) ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage running lw/sw as a valid/ready bus transaction with
// alignment check, bus timeout and core stall.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUOut_i,
  input  logic [31:0] StoreData_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] WriteData_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;
  logic        acc, aligned, start, expired;
  logic [CNT_W-1:0] cnt_unused;

  assign acc     = MemRead_i | MemWrite_i;
  assign aligned = ALUOut_i[1:0] == 2'b00;
  assign start   = state_q == IDLE && acc && aligned;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != BUSY),
    .enable_i (state_q == BUSY),
    .count_o  (cnt_unused),
    .expired_o(expired)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    misalign_d = 1'b0;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = ALUOut_i;
          wdata_d = StoreData_i;
        end
        misalign_d = acc && !aligned;
      end
      BUSY: begin
        // A ready arriving on the last permitted cycle still completes normally.
        if (mem_ready_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          rbuf_d  = we_q ? rbuf_q : mem_rdata_i;
        end else if (expired) begin
          state_d   = DONE;
          req_d     = 1'b0;
          rbuf_d    = '0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign misalign_o  = misalign_q;
  assign timeout_o   = timeout_q;
  assign stall_o     = rst && (start || state_q == BUSY);
  assign WriteData_o = !rst             ? '0 :
                       state_q == DONE  ? (we_q ? ALUOut_i : rbuf_q) :
                       state_q == IDLE && !acc ? ALUOut_i : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit with a 4-cycle timeout.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead_i = 1'b0, MemWrite_i = 1'b0;
  logic [31:0] ALUOut_i = '0, StoreData_i = '0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_req_o, mem_we_o, stall_o, misalign_o, timeout_o;
  logic [31:0] mem_addr_o, mem_wdata_o, WriteData_o;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .ALUOut_i   (ALUOut_i),
    .StoreData_i(StoreData_i),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i),
    .stall_o    (stall_o),
    .WriteData_o(WriteData_o),
    .misalign_o (misalign_o),
    .timeout_o  (timeout_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wb;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One lw/sw through the bus; memory raises ready after `waits` wait cycles.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata, input int waits);
    exp_t e, got;
    int   req_n = 0, stall_n = 0, exp_req;
    exp_req = (waits + 1 > TO) ? TO : waits + 1;
    e.we    = wr;
    e.addr  = addr;
    e.wdata = sdata;
    e.wb    = wr ? addr : (waits < TO ? rdata : 32'h0);
    got     = e;
    @(negedge clk);
    MemRead_i   = rd;
    MemWrite_i  = wr;
    ALUOut_i    = addr;
    StoreData_i = sdata;
    mem_ready_i = 1'b0;
    sb.push_back(e);
    #1;
    chk("idle_req", mem_req_o, 0);
    if (stall_o) stall_n++;
    @(negedge clk);
    while (mem_req_o && req_n < 40) begin
      if (req_n == 0 && sb.size() > 0) got = sb.pop_front();
      chk("addr", mem_addr_o, got.addr);
      chk("we", mem_we_o, got.we);
      chk("wdata", mem_wdata_o, got.wdata);
      chk("busy_stall", stall_o, 1);
      if (stall_o) stall_n++;
      mem_ready_i = req_n == waits;
      mem_rdata_i = req_n == waits ? rdata : 32'hBAD0_BAD0;
      req_n++;
      @(negedge clk);
    end
    mem_ready_i = 1'b0;
    chk("req_cycles", req_n, exp_req);
    chk("stall_cycles", stall_n, exp_req + 1);
    #1;
    chk("done_stall", stall_o, 0);
    chk("done_wb", WriteData_o, got.wb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    MemRead_i = 1'b1;
    ALUOut_i  = 32'h77;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_wd", WriteData_o, 0);

    @(negedge clk);
    rst = 1'b1;
    MemRead_i = 1'b0;
    ALUOut_i = 32'h10;
    #1;
    chk("alu_wd", WriteData_o, 32'h10);
    chk("alu_stall", stall_o, 0);
    chk("alu_req", mem_req_o, 0);
    @(negedge clk);
    ALUOut_i = 32'hCAFE_0001;
    #1;
    chk("alu_req2", mem_req_o, 0);
    chk("alu_wd2", WriteData_o, 32'hCAFE_0001);

    access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    access(1'b0, 1'b1, 32'h200, 32'h1234_5678, 32'h0, 3);
    access(1'b1, 1'b0, 32'h104, 32'h0, 32'h3C3C_A5A5, 1);
    access(1'b1, 1'b1, 32'h108, 32'hAAAA_5555, 32'h0, 0);

    @(negedge clk);
    MemRead_i = 1'b1;
    MemWrite_i = 1'b0;
    ALUOut_i = 32'h102;
    #1;
    chk("mis_ld_stall", stall_o, 0);
    chk("mis_ld_wd", WriteData_o, 0);
    @(negedge clk);
    MemRead_i = 1'b0;
    ALUOut_i = 32'h0;
    #1;
    chk("mis_ld_pulse", misalign_o, 1);
    chk("mis_ld_req", mem_req_o, 0);
    chk("mis_ld_stall2", stall_o, 0);
    @(negedge clk);
    MemWrite_i = 1'b1;
    ALUOut_i = 32'h201;
    StoreData_i = 32'h9999_9999;
    #1;
    chk("mis_pulse_end", misalign_o, 0);
    chk("mis_st_stall", stall_o, 0);
    @(negedge clk);
    MemWrite_i = 1'b0;
    #1;
    chk("mis_st_pulse", misalign_o, 1);
    chk("mis_st_req", mem_req_o, 0);
    chk("pre_timeout", timeout_o, 0);

    access(1'b1, 1'b0, 32'h300, 32'h0, 32'hFFFF_FFFF, 99);
    chk("timeout_set", timeout_o, 1);
    @(negedge clk);
    MemRead_i = 1'b0;
    #1;
    chk("timeout_sticky", timeout_o, 1);

    @(negedge clk);
    MemRead_i = 1'b1;
    ALUOut_i = 32'h400;
    @(negedge clk);
    chk("rstmid_busy1", mem_req_o, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid_req", mem_req_o, 0);
    chk("rstmid_stall", stall_o, 0);
    chk("rstmid_timeout", timeout_o, 0);
    chk("rstmid_wd", WriteData_o, 0);
    rst = 1'b1;
    MemRead_i = 1'b0;
    ALUOut_i = 32'h55;
    @(negedge clk);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h1;
    @(negedge clk);
    mem_ready_i = 1'b0;
    #1;
    chk("late_ready_req", mem_req_o, 0);
    chk("late_ready_stall", stall_o, 0);
    chk("late_ready_wd", WriteData_o, 32'h55);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage directly downstream of the ALU stage.
- Consumes the ALU result as a data address plus register-file store data, and runs a multi-cycle valid/ready transaction to data memory for lw/sw.
- Stalls the core while a transaction is outstanding.
- Delivers the write-back value: load data for lw, the ALU result for everything else.
- Word accesses only; alignment check and bus timeout included.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in BUSY waiting for mem_ready_i before the access is aborted. Range 1..65535.
- CNT_W, 16: width of the timeout counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- MemRead_i  in  1  control: current instruction is lw
- MemWrite_i  in  1  control: current instruction is sw
- ALUOut_i  in  32  ALU result (address for lw/sw, result otherwise)
- StoreData_i  in  32  rs2 value for sw
- mem_req_o  out  1  bus request valid
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  word address (byte address, [1:0]=0)
- mem_wdata_o  out  32  store data
- mem_ready_i  in  1  bus accept/complete strobe
- mem_rdata_i  in  32  read data, valid when mem_ready_i=1 on a read
- stall_o  out  1  hold PC and pipeline inputs
- WriteData_o  out  32  value to register file write port
- misalign_o  out  1  one-cycle pulse: misaligned access dropped
- timeout_o  out  1  sticky: a transaction timed out

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; mem_req_o, mem_we_o, misalign_o, timeout_o=0; mem_addr_o, mem_wdata_o, load buffer, counter=0. While rst=0, stall_o=0 and WriteData_o=0.
- A reset mid-transaction aborts it; mem_req_o drops on that edge.
- Access request: acc = MemRead_i | MemWrite_i. If both are high, treat as a write.
- FSM states are IDLE, BUSY, DONE.
- IDLE, acc=0:
  - WriteData_o = ALUOut_i (combinational); stall_o=0.
- IDLE, acc=1, ALUOut_i[1:0]!=0:
  - No bus request is issued.
  - misalign_o=1 for the next cycle only.
  - stall_o=0; WriteData_o=0 for a load; the store is discarded.
- IDLE, acc=1, aligned:
  - stall_o=1 combinationally.
  - On the edge: register addr/wdata/we, mem_req_o=1, counter=0, go to BUSY.
- BUSY:
  - stall_o=1; mem_req_o and address/data held stable.
  - Counter increments each cycle.
  - If mem_ready_i=1: capture mem_rdata_i (reads), mem_req_o=0, go to DONE.
  - Else if counter==TIMEOUT_CYCLES-1: mem_req_o=0, load buffer=0, timeout_o=1, go to DONE.
  - A mem_ready_i that arrives in the same cycle as the timeout wins: the transaction completes normally.
- DONE:
  - stall_o=0; WriteData_o = load buffer for a read, ALUOut_i for a write.
  - Next state is IDLE unconditionally. The core advances at the end of this cycle.
- Latency, aligned access with zero-wait memory: 3 cycles (IDLE, BUSY, DONE); stall_o high for 2.
- Back-to-back accesses: the IDLE cycle after DONE re-evaluates the new instruction. No access is skipped or duplicated.
- mem_ready_i while in IDLE or DONE is ignored.
- timeout_o clears only on reset.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the ALUop constants used by the control unit (lw/jalr 5'b10100, sw 5'b10101);
  - the default TIMEOUT_CYCLES.
- One natural sub-module: mem_timeout_counter.
  - Inputs: clk, rst, clear, enable.
  - Outputs: count, expired.
  - Parameterised by TIMEOUT_CYCLES and CNT_W.

Test Plan:
- Non-memory op, ALUOut_i=32'h0000_0010, MemRead=MemWrite=0 → WriteData_o=32'h10 the same cycle, stall_o=0, mem_req_o never asserted.
- lw, ALUOut_i=32'h0000_0100, memory returns ready with 32'hDEAD_BEEF in the first BUSY cycle → mem_req_o=1 for 1 cycle, addr=32'h100, we=0; stall_o high for 2 cycles; WriteData_o=32'hDEADBEEF in DONE.
- sw, ALUOut_i=32'h0000_0200, StoreData_i=32'h1234_5678, ready after 3 wait cycles → mem_req_o high for 4 cycles with addr/wdata stable, we=1; stall_o high for 5 cycles.
- lw with ALUOut_i=32'h0000_0102 → no mem_req_o, misalign_o pulses for 1 cycle, WriteData_o=0, stall_o=0.
- TIMEOUT_CYCLES=4, lw, mem_ready_i held 0 → mem_req_o drops after 4 BUSY cycles; timeout_o=1 and stays 1; WriteData_o=0 in DONE.
- rst=0 asserted in the second BUSY cycle → next edge: state IDLE, mem_req_o=0, stall_o=0, timeout_o=0. A later mem_ready_i pulse has no effect.
